// File: rtl/ssd_scan_driver.sv
// Four-digit common-anode seven-segment scan driver with per-frame digit snapshot.
// Latency: anode/segment/DP are registered from the current (index, tick), one cycle behind.
// Backpressure: none; free-running scan, inputs are sampled once per frame.
//
// Ports:
//   i_CLK, i_RST             clock, asynchronous active-high reset
//   i_Digit_1_val..4_val     digit values, digit 1 is leftmost
//   i_DP_mask                decimal point enables, bit 3 = digit 1
//   i_Blank_Leading          suppress leading zeros on digits 1-3
//   o_Anode                  active-low digit enables, bit 3 = digit 1
//   o_Segment                active-low segments g..a
//   o_DP                     active-low decimal point
//   o_Frame_Start            one-cycle pulse after each snapshot
module ssd_scan_driver #(
  parameter int c_REFRESH_DIV = 100000,
  parameter int c_DEAD_CYCLES = 1000
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic [3:0] i_Digit_1_val,
  input  logic [3:0] i_Digit_2_val,
  input  logic [3:0] i_Digit_3_val,
  input  logic [3:0] i_Digit_4_val,
  input  logic [3:0] i_DP_mask,
  input  logic       i_Blank_Leading,
  output logic [3:0] o_Anode,
  output logic [6:0] o_Segment,
  output logic       o_DP,
  output logic       o_Frame_Start
);

  localparam int TW = (c_REFRESH_DIV > 1) ? $clog2(c_REFRESH_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(c_REFRESH_DIV - 1);

  logic [TW-1:0]     tick_q, tick_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0][3:0]   dig_q, dig_d;     // [0] = digit 1 ... [3] = digit 4
  logic [3:0]        dpm_q, dpm_d;
  logic              bl_q, bl_d;
  logic [3:0]        anode_q, anode_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic              fs_q;

  logic              snap_en;
  logic              in_dead;
  logic [3:0]        blank;
  logic              lit;

  // Hex to active-low g..a segment pattern.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  generate
    if (c_DEAD_CYCLES == 0) begin : g_no_dead
      assign in_dead = 1'b0;
    end else begin : g_dead
      assign in_dead = (tick_q < TW'(c_DEAD_CYCLES));
    end
  endgenerate

  always_comb begin
    snap_en = (tick_q == '0) && (idx_q == 2'd0);

    // Snapshot mux: the display path uses the post-snapshot values so that a
    // zero dead time still shows fresh data in the first slot of the frame.
    dig_d = dig_q;
    dpm_d = dpm_q;
    bl_d  = bl_q;
    if (snap_en) begin
      dig_d[0] = i_Digit_1_val;
      dig_d[1] = i_Digit_2_val;
      dig_d[2] = i_Digit_3_val;
      dig_d[3] = i_Digit_4_val;
      dpm_d    = i_DP_mask;
      bl_d     = i_Blank_Leading;
    end

    if (tick_q == TICK_LAST) begin
      tick_d = '0;
      idx_d  = idx_q + 2'd1;
    end else begin
      tick_d = tick_q + 1'b1;
      idx_d  = idx_q;
    end

    // A digit is a leading zero only if every digit to its left is too.
    blank[0] = bl_d && (dig_d[0] == 4'd0);
    blank[1] = blank[0] && (dig_d[1] == 4'd0);
    blank[2] = blank[1] && (dig_d[2] == 4'd0);
    blank[3] = 1'b0;

    lit = !in_dead && !blank[idx_q];

    anode_d = 4'b1111;
    seg_d   = 7'b1111111;
    dp_d    = 1'b1;
    if (lit) begin
      anode_d = ~(4'b1000 >> idx_q);
      seg_d   = decode(dig_d[idx_q]);
      dp_d    = ~dpm_d[2'd3 - idx_q];
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      tick_q  <= '0;
      idx_q   <= 2'd0;
      dig_q   <= '0;
      dpm_q   <= 4'd0;
      bl_q    <= 1'b0;
      anode_q <= 4'b1111;
      seg_q   <= 7'b1111111;
      dp_q    <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
      dpm_q   <= dpm_d;
      bl_q    <= bl_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      fs_q    <= snap_en;
    end
  end

  assign o_Anode       = anode_q;
  assign o_Segment     = seg_q;
  assign o_DP          = dp_q;
  assign o_Frame_Start = fs_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
module tb_ssd_scan_driver;

  localparam int DIV  = 8;
  localparam int DEAD = 2;
  localparam int FRM  = 4 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] d1 = 4'd0, d2 = 4'd0, d3 = 4'd0, d4 = 4'd0;
  logic [3:0] dpm = 4'd0;
  logic       bl = 1'b0;
  logic [3:0] o_Anode;
  logic [6:0] o_Segment;
  logic       o_DP;
  logic       o_Frame_Start;

  int checks = 0;
  int errors = 0;

  // Model of the snapshot that should be on display.
  logic [3:0] m_dig [4];
  logic [3:0] m_mask;
  logic       m_bl;

  logic [3:0] cap_an  [FRM];
  logic [6:0] cap_seg [FRM];
  logic       cap_dp  [FRM];
  logic       cap_fs  [FRM];

  ssd_scan_driver #(.c_REFRESH_DIV(DIV), .c_DEAD_CYCLES(DEAD)) dut (
    .i_CLK(clk), .i_RST(rst),
    .i_Digit_1_val(d1), .i_Digit_2_val(d2), .i_Digit_3_val(d3), .i_Digit_4_val(d4),
    .i_DP_mask(dpm), .i_Blank_Leading(bl),
    .o_Anode(o_Anode), .o_Segment(o_Segment), .o_DP(o_DP), .o_Frame_Start(o_Frame_Start)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] dec(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[v];
  endfunction

  function automatic bit m_lit(input int j);
    int  s;
    bit  z;
    s = j / DIV;
    if ((j % DIV) < DEAD) return 1'b0;
    if (s == 3 || !m_bl) return 1'b1;
    z = 1'b1;
    for (int k = 0; k <= s; k++) if (m_dig[k] != 4'd0) z = 1'b0;
    return !z;
  endfunction

  function automatic logic [3:0] m_an(input int j);
    logic [3:0] a;
    a = 4'b1111;
    a[3 - j / DIV] = 1'b0;
    return m_lit(j) ? a : 4'b1111;
  endfunction

  function automatic logic [6:0] m_seg(input int j);
    return m_lit(j) ? dec(m_dig[j / DIV]) : 7'b1111111;
  endfunction

  function automatic logic m_dp(input int j);
    return m_lit(j) ? ~m_mask[3 - j / DIV] : 1'b1;
  endfunction

  task automatic set_in(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] d, input logic [3:0] mk, input logic bk);
    d1 = a; d2 = b; d3 = c; d4 = d; dpm = mk; bl = bk;
    m_dig[0] = a; m_dig[1] = b; m_dig[2] = c; m_dig[3] = d; m_mask = mk; m_bl = bk;
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_Frame_Start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Captures one frame; index 0 is the Frame_Start cycle. Returns on the last cycle.
  task automatic capture_frame(output bit ok);
    wait_fs(ok);
    if (!ok) return;
    for (int j = 0; j < FRM; j++) begin
      if (j > 0) @(negedge clk);
      cap_an[j] = o_Anode; cap_seg[j] = o_Segment; cap_dp[j] = o_DP; cap_fs[j] = o_Frame_Start;
    end
  endtask

  task automatic test_reset;
    int n;
    set_in(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 1'b0);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (o_Anode !== 4'b1111 || o_Segment !== 7'b1111111 || o_DP !== 1'b1 || o_Frame_Start !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold an=%b seg=%b dp=%b fs=%b expected 1111 1111111 1 0",
                 o_Anode, o_Segment, o_DP, o_Frame_Start);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (o_Frame_Start !== 1'b1 || o_Anode !== 4'b1111) begin
      errors++;
      $display("FAIL reset_first_fs fs=%b an=%b expected 1 1111", o_Frame_Start, o_Anode);
    end
    @(negedge clk);
    checks++;
    if (o_Frame_Start !== 1'b0 || o_Anode !== 4'b1111) begin
      errors++;
      $display("FAIL reset_dead fs=%b an=%b expected 0 1111", o_Frame_Start, o_Anode);
    end
    @(negedge clk);
    checks++;
    if (o_Anode !== 4'b0111 || o_Segment !== 7'b1111001) begin
      errors++;
      $display("FAIL reset_first_lit an=%b seg=%b expected 0111 1111001", o_Anode, o_Segment);
    end
    n = 0;
    for (int j = 3; j < FRM; j++) begin
      @(negedge clk);
      if (o_Frame_Start) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL reset_single_pulse extra_pulses=%0d expected 0", n);
    end
  endtask

  task automatic test_full_scan;
    bit ok;
    int nfs;
    set_in(4'd1, 4'd2, 4'd3, 4'd4, 4'b0100, 1'b0);
    capture_frame(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL scan_timeout got=0 expected=1"); return; end
    nfs = 0;
    for (int j = 0; j < FRM; j++) begin
      if (cap_fs[j]) nfs++;
      checks++;
      if (cap_an[j] !== m_an(j) || cap_seg[j] !== m_seg(j) || cap_dp[j] !== m_dp(j)) begin
        errors++;
        $display("FAIL scan cyc=%0d an=%b seg=%b dp=%b expected %b %b %b",
                 j, cap_an[j], cap_seg[j], cap_dp[j], m_an(j), m_seg(j), m_dp(j));
      end
    end
    // Hand-picked anchors: digit 2 lit with DP, digit 4 shows "4".
    checks++;
    if (cap_an[10] !== 4'b1011 || cap_seg[10] !== 7'b0100100 || cap_dp[10] !== 1'b0) begin
      errors++;
      $display("FAIL scan_digit2 an=%b seg=%b dp=%b expected 1011 0100100 0", cap_an[10], cap_seg[10], cap_dp[10]);
    end
    checks++;
    if (cap_an[31] !== 4'b1110 || cap_seg[31] !== 7'b0011001 || cap_dp[31] !== 1'b1) begin
      errors++;
      $display("FAIL scan_digit4 an=%b seg=%b dp=%b expected 1110 0011001 1", cap_an[31], cap_seg[31], cap_dp[31]);
    end
    @(negedge clk);
    checks++;
    if (nfs != 1 || o_Frame_Start !== 1'b1) begin
      errors++;
      $display("FAIL scan_period pulses=%0d next_fs=%b expected 1 1", nfs, o_Frame_Start);
    end
  endtask

  task automatic test_coherence;
    bit ok;
    set_in(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 1'b0);
    wait_fs(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL coh_timeout got=0 expected=1"); return; end
    for (int j = 1; j < FRM; j++) begin
      @(negedge clk);
      if (j == 10) d4 = 4'd9;
      if (j >= 24 + DEAD) begin
        checks++;
        if (o_Anode !== 4'b1110 || o_Segment !== 7'b0011001) begin
          errors++;
          $display("FAIL coh_old cyc=%0d an=%b seg=%b expected 1110 0011001", j, o_Anode, o_Segment);
        end
      end
    end
    m_dig[3] = 4'd9;
    capture_frame(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL coh_timeout2 got=0 expected=1"); return; end
    for (int j = 24 + DEAD; j < FRM; j++) begin
      checks++;
      if (cap_an[j] !== 4'b1110 || cap_seg[j] !== 7'b0010000) begin
        errors++;
        $display("FAIL coh_new cyc=%0d an=%b seg=%b expected 1110 0010000", j, cap_an[j], cap_seg[j]);
      end
    end
  endtask

  task automatic test_leading_blank;
    bit ok;
    set_in(4'd0, 4'd0, 4'd5, 4'd0, 4'b1111, 1'b1);
    capture_frame(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL blank_timeout got=0 expected=1"); return; end
    for (int j = 0; j < FRM; j++) begin
      checks++;
      if (cap_an[j] !== m_an(j) || cap_seg[j] !== m_seg(j) || cap_dp[j] !== m_dp(j)
          || cap_an[j] === 4'b0111 || cap_an[j] === 4'b1011) begin
        errors++;
        $display("FAIL blank_005 cyc=%0d an=%b seg=%b dp=%b expected %b %b %b",
                 j, cap_an[j], cap_seg[j], cap_dp[j], m_an(j), m_seg(j), m_dp(j));
      end
    end
    checks++;
    if (cap_seg[20] !== 7'b0010010 || cap_seg[28] !== 7'b1000000) begin
      errors++;
      $display("FAIL blank_digits seg3=%b seg4=%b expected 0010010 1000000", cap_seg[20], cap_seg[28]);
    end
    set_in(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b1);
    capture_frame(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL blank0_timeout got=0 expected=1"); return; end
    for (int j = 0; j < FRM; j++) begin
      checks++;
      if (cap_an[j] !== ((j >= 24 + DEAD) ? 4'b1110 : 4'b1111) || cap_seg[j] !== m_seg(j)) begin
        errors++;
        $display("FAIL blank_000 cyc=%0d an=%b seg=%b expected %b %b",
                 j, cap_an[j], cap_seg[j], m_an(j), m_seg(j));
      end
    end
  endtask

  task automatic test_hex;
    bit ok;
    for (int f = 0; f < 16; f++) begin
      set_in(4'(f), 4'(f + 1), 4'(f + 2), 4'(f + 3), 4'(f), 1'b0);
      capture_frame(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL hex_timeout frame=%0d got=0 expected=1", f); return; end
      for (int j = 0; j < FRM; j++) begin
        checks++;
        if (cap_an[j] !== m_an(j) || cap_seg[j] !== m_seg(j) || cap_dp[j] !== m_dp(j)
            || $countones(~cap_an[j]) > 1) begin
          errors++;
          $display("FAIL hex frame=%0d cyc=%0d an=%b seg=%b dp=%b expected %b %b %b",
                   f, j, cap_an[j], cap_seg[j], cap_dp[j], m_an(j), m_seg(j), m_dp(j));
        end
      end
    end
  endtask

  task automatic test_mid_reset;
    bit ok;
    set_in(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 1'b0);
    wait_fs(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mrst_timeout got=0 expected=1"); return; end
    repeat (2 * DIV + 4) @(negedge clk);
    checks++;
    if (o_Anode !== 4'b1101 || o_Segment !== 7'b0110000) begin
      errors++;
      $display("FAIL mrst_pre an=%b seg=%b expected 1101 0110000", o_Anode, o_Segment);
    end
    d1 = 4'd7;
    rst = 1'b1;
    #1;
    checks++;
    if (o_Anode !== 4'b1111 || o_Segment !== 7'b1111111 || o_DP !== 1'b1 || o_Frame_Start !== 1'b0) begin
      errors++;
      $display("FAIL mrst_async an=%b seg=%b dp=%b fs=%b expected 1111 1111111 1 0",
               o_Anode, o_Segment, o_DP, o_Frame_Start);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (o_Frame_Start !== 1'b1 || o_Anode !== 4'b1111) begin
      errors++;
      $display("FAIL mrst_fs fs=%b an=%b expected 1 1111", o_Frame_Start, o_Anode);
    end
    repeat (DEAD) @(negedge clk);
    checks++;
    if (o_Anode !== 4'b0111 || o_Segment !== 7'b1111000) begin
      errors++;
      $display("FAIL mrst_restart an=%b seg=%b expected 0111 1111000", o_Anode, o_Segment);
    end
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_coherence();
    test_leading_blank();
    test_hex();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssd_scan_driver.md
Name: ssd_scan_driver

Overview:
- Consumes the four 4-bit stopwatch digit values and drives a 4-digit, common-anode, time-multiplexed seven-segment display.
- Sits between the digit counter and the board pins.
- Takes a coherent per-frame snapshot of the digits, scans one digit at a time with a dead-time gap between digits, and decodes 0-F to segments.
- Supports optional leading-zero blanking and per-digit decimal points.

Parameters:
c_REFRESH_DIV, 100000, clock cycles per digit slot (1 kHz per digit at 100 MHz); legal range >= 2.
c_DEAD_CYCLES, 1000, cycles at the start of each slot with all anodes off (anti-ghosting); legal range 0 <= value < c_REFRESH_DIV.

Ports:
i_CLK  input  1  system clock; all registers update on its rising edge.
i_RST  input  1  asynchronous, active-high reset.
i_Digit_1_val  input  4  most-significant digit (leftmost), value 0-15.
i_Digit_2_val  input  4  second digit.
i_Digit_3_val  input  4  third digit.
i_Digit_4_val  input  4  least-significant digit (rightmost).
i_DP_mask  input  4  decimal point enables; bit 3 = digit 1 ... bit 0 = digit 4.
i_Blank_Leading  input  1  1 = suppress leading zeros on digits 1-3.
o_Anode  output  4  active-low digit enables; bit 3 = digit 1 ... bit 0 = digit 4.
o_Segment  output  7  active-low segments; bit 6..0 = g,f,e,d,c,b,a.
o_DP  output  1  active-low decimal point.
o_Frame_Start  output  1  one-cycle pulse marking a new snapshot.

Behaviour:
- Reset (async, while i_RST=1):
  - o_Anode=4'b1111, o_Segment=7'b1111111, o_DP=1, o_Frame_Start=0.
  - Slot tick=0, digit index=0 (digit 1), snapshot registers=0.
- Slot counter:
  - Tick counts 0..c_REFRESH_DIV-1, then wraps to 0.
  - On wrap, the index advances 0->1->2->3->0.
  - Counter width is $clog2(c_REFRESH_DIV).
- Snapshot:
  - On every edge where tick==0 and index==0, the four digits, i_DP_mask and i_Blank_Leading are latched.
  - This includes the first edge after reset release.
  - o_Frame_Start is 1 for exactly the following cycle.
  - Input changes mid-frame have no visible effect until the next snapshot.
- Per-slot display:
  - For tick < c_DEAD_CYCLES, all anodes are off.
  - Otherwise, the anode of the current index is low if that digit is not blanked.
  - Segments show the decoded snapshot value of the current index; o_DP = ~mask bit of the current index.
  - When no anode is active, o_Segment=7'b1111111 and o_DP=1.
- Latency: o_Anode, o_Segment and o_DP are registered from the current (index, tick), giving one cycle of latency. Consequently:
  - Each lit digit is low for exactly c_REFRESH_DIV-c_DEAD_CYCLES cycles per slot.
  - Dark gaps last exactly c_DEAD_CYCLES cycles.
  - A frame is 4*c_REFRESH_DIV cycles.
  - With c_DEAD_CYCLES=0, the anode changes directly with no gap and never has two bits low simultaneously.
- Leading-zero blanking (snapshot i_Blank_Leading=1):
  - Digit k (k=1..3) is blanked iff it and all more-significant digits are 0.
  - Digit 4 is never blanked.
  - A blanked digit keeps its anode off for the whole slot, including DP.
- Decode, g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Invariant: at most one o_Anode bit is low in any cycle.
- Reset mid-operation: outputs return to reset values immediately (asynchronously). After release the scan restarts at digit 1 with a fresh snapshot and an o_Frame_Start pulse.

Test Plan:
(All with c_REFRESH_DIV=8, c_DEAD_CYCLES=2.)
- Reset sequence: hold i_RST 3 cycles with digits=1,2,3,4 -> o_Anode=1111, o_Segment=1111111, o_DP=1 during reset; o_Frame_Start pulses once after release; first lit state is o_Anode=0111 with o_Segment=1111001.
- Full scan: digits 1,2,3,4, DP mask 0100 -> anodes 0111, 1011, 1101, 1110 each low 6 cycles with 2 dark cycles between; segments 1111001, 0100100, 0110000, 0011001; o_DP=0 only while o_Anode=1011; frame period 32 cycles.
- Snapshot coherence: change digit 4 from 4 to 9 while digit 2 is lit -> digit 4 still shows 0011001 this frame; shows 0010000 after the next o_Frame_Start.
- Leading blank: Blank=1, digits 0,0,5,0 -> digits 1 and 2 never lit; digit 3 shows 0010010; digit 4 shows 1000000. With digits 0,0,0,0, only o_Anode=1110 appears.
- Hex decode: Blank=0, walk all digits through 0-F over 16 frames -> every value matches the decode table; no two anode bits are low in any cycle.
- Mid-slot reset: assert i_RST at tick 4 of digit 3 -> same-cycle o_Anode=1111; after release the scan restarts at digit 1 with a fresh snapshot and an o_Frame_Start pulse.
